// File: rtl/pipe_pkg.sv
//==============================================================================
// Module      : pipe_pkg
// Description : Shared state encodings and packed stage payloads for pipeline
//               boundary registers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        EMPTY = ST_EMPTY,
        BUSY  = ST_BUSY,
        FULL  = ST_FULL
    } pipe_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_id_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } id_ex_t;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg_sat_counter.sv
//==============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != C_MAX)) begin
            count_d = count_q + C_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
//==============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline stage register with optional skid buffer,
//               synchronous flush and saturating stall counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic [1:0]        state_q, state_d;
            logic [DATA_W-1:0] main_q, main_d;
            logic [DATA_W-1:0] skid_q, skid_d;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (flush) begin
                    state_d = ST_EMPTY;
                end else begin
                    case (state_q)
                        ST_EMPTY: begin
                            if (in_xfer) begin
                                main_d  = in_data;
                                state_d = ST_BUSY;
                            end
                        end
                        ST_BUSY: begin
                            if (in_xfer && out_xfer) begin
                                main_d = in_data;
                            end else if (in_xfer) begin
                                skid_d  = in_data;
                                state_d = ST_FULL;
                            end else if (out_xfer) begin
                                state_d = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            // in_ready is low here, so only the drain case exists
                            if (out_xfer) begin
                                main_d  = skid_q;
                                state_d = ST_BUSY;
                            end
                        end
                        default: state_d = ST_EMPTY;
                    endcase
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    state_q <= ST_EMPTY;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end

            assign in_ready  = (state_q != ST_FULL);
            assign out_valid = (state_q != ST_EMPTY);
            assign out_data  = main_q;
        end else begin : g_single
            logic              valid_q, valid_d;
            logic [DATA_W-1:0] data_q, data_d;

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (flush) begin
                    valid_d = 1'b0;
                end else if (in_xfer) begin
                    data_d  = in_data;
                    valid_d = 1'b1;
                end else if (out_xfer) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end

            assign in_ready  = !valid_q || out_ready;
            assign out_valid = valid_q;
            assign out_data  = data_q;
        end
    endgenerate

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .clear (RST),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
//==============================================================================
// Module      : tb_pipe_stage_reg
// Description : Directed bench for a skid instance (narrow counter) and a
//               single-register instance carrying an if_id_t payload.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int C_W1 = 32;
    localparam int C_W0 = $bits(if_id_t);

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    // skid instance
    logic            fl1, iv1, ir1, ov1, or1;
    logic [C_W1-1:0] id1, od1;
    logic [3:0]      st1;

    // single-register instance
    logic            fl0, iv0, ir0, ov0, or0;
    logic [C_W0-1:0] id0, od0;
    logic [15:0]     st0;

    pipe_stage_reg #(.DATA_W(C_W1), .SKID(1), .CNT_W(4)) u_dut1 (
        .CLK(CLK), .RST(RST), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
        .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1),
        .stall_cnt(st1)
    );

    pipe_stage_reg #(.DATA_W(C_W0), .SKID(0), .CNT_W(16)) u_dut0 (
        .CLK(CLK), .RST(RST), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
        .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
        .stall_cnt(st0)
    );

    typedef struct packed {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_od;
        logic        e_ir;
        logic [3:0]  e_st;
    } vec_t;

    vec_t vecs [13];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // streaming, backpressure drain, flush while FULL with a concurrent input
        vecs[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 32'h11, 1'b1, 4'd0};
        vecs[1]  = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b1, 32'h22, 1'b1, 4'd0};
        vecs[2]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h33, 1'b1, 4'd0};
        vecs[3]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h33, 1'b1, 4'd0};
        vecs[4]  = '{1'b1, 32'hA0, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b1, 4'd0};
        vecs[5]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0, 4'd1};
        vecs[6]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'hA0, 1'b0, 4'd2};
        vecs[7]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'hA1, 1'b1, 4'd2};
        vecs[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'hA1, 1'b1, 4'd2};
        vecs[9]  = '{1'b1, 32'hB0, 1'b0, 1'b0, 1'b1, 32'hB0, 1'b1, 4'd2};
        vecs[10] = '{1'b1, 32'hB1, 1'b0, 1'b0, 1'b1, 32'hB0, 1'b0, 4'd3};
        vecs[11] = '{1'b1, 32'hB2, 1'b0, 1'b1, 1'b0, 32'hB0, 1'b1, 4'd4};
        vecs[12] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'hB0, 1'b1, 4'd4};

        RST = 1'b1;
        fl1 = 1'b0; iv1 = 1'b0; id1 = '0; or1 = 1'b0;
        fl0 = 1'b0; iv0 = 1'b0; id0 = '0; or0 = 1'b0;
        tick();
        tick();
        chk("rst1_ov", 64'(ov1), 64'd0);
        chk("rst1_od", 64'(od1), 64'd0);
        chk("rst1_ir", 64'(ir1), 64'd1);
        chk("rst1_st", 64'(st1), 64'd0);
        chk("rst0_ov", 64'(ov0), 64'd0);
        chk("rst0_od", od0, 64'd0);
        chk("rst0_st", 64'(st0), 64'd0);
        RST = 1'b0;

        for (int i = 0; i < 13; i++) begin
            iv1 = vecs[i].iv; id1 = vecs[i].d; or1 = vecs[i].ordy; fl1 = vecs[i].fl;
            tick();
            chk($sformatf("v%0d_ov", i), 64'(ov1), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d_od", i), 64'(od1), 64'(vecs[i].e_od));
            chk($sformatf("v%0d_ir", i), 64'(ir1), 64'(vecs[i].e_ir));
            chk($sformatf("v%0d_st", i), 64'(st1), 64'(vecs[i].e_st));
        end

        // saturation: stall counter enters at 4, climbs one per stalled edge
        iv1 = 1'b1; id1 = 32'hC0; or1 = 1'b0; fl1 = 1'b0;
        tick();
        iv1 = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 5)  chk("sat_k5", 64'(st1), 64'd9);
            if (k == 11) chk("sat_k11", 64'(st1), 64'd15);
        end
        chk("sat_k20", 64'(st1), 64'd15);
        chk("sat_hold_od", 64'(od1), 64'hC0);
        chk("sat_hold_ov", 64'(ov1), 64'd1);
        fl1 = 1'b1;
        tick();
        fl1 = 1'b0;
        chk("sat_flush_st", 64'(st1), 64'd15);
        chk("sat_flush_ov", 64'(ov1), 64'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("sat_rst_st", 64'(st1), 64'd0);

        // reset with both entries held and a concurrent handshake
        iv1 = 1'b1; id1 = 32'hD0; or1 = 1'b0;
        tick();
        id1 = 32'hD1;
        tick();
        chk("mid_full_ir", 64'(ir1), 64'd0);
        RST = 1'b1; id1 = 32'hD2; or1 = 1'b1;
        tick();
        RST = 1'b0;
        chk("mid_rst_ov", 64'(ov1), 64'd0);
        chk("mid_rst_od", 64'(od1), 64'd0);
        chk("mid_rst_ir", 64'(ir1), 64'd1);
        id1 = 32'hE0;
        tick();
        iv1 = 1'b0;
        chk("mid_e0_ov", 64'(ov1), 64'd1);
        chk("mid_e0_od", 64'(od1), 64'hE0);
        tick();
        chk("mid_drain_ov", 64'(ov1), 64'd0);

        // single-register: in_ready follows out_ready combinationally
        iv0 = 1'b1; id0 = {32'h1000, 32'h0001}; or0 = 1'b1;
        tick();
        chk("s0_p1_od", od0, {32'h1000, 32'h0001});
        id0 = {32'h1004, 32'h0002};
        #1;
        chk("s0_ir_a", 64'(ir0), 64'd1);
        tick();
        chk("s0_p2_od", od0, {32'h1004, 32'h0002});
        id0 = {32'h1008, 32'h0003}; or0 = 1'b0;
        #1;
        chk("s0_ir_b", 64'(ir0), 64'd0);
        tick();
        chk("s0_hold_od", od0, {32'h1004, 32'h0002});
        chk("s0_hold_ov", 64'(ov0), 64'd1);
        or0 = 1'b1;
        #1;
        chk("s0_ir_c", 64'(ir0), 64'd1);
        tick();
        chk("s0_p3_od", od0, {32'h1008, 32'h0003});
        iv0 = 1'b0;
        tick();
        chk("s0_drain_ov", 64'(ov0), 64'd0);
        chk("s0_st", 64'(st0), 64'd1);
        iv0 = 1'b1; id0 = {32'h2000, 32'h0009}; fl0 = 1'b1;
        tick();
        fl0 = 1'b0; iv0 = 1'b0;
        chk("s0_flush_ov", 64'(ov0), 64'd0);
        chk("s0_flush_od", od0, {32'h1008, 32'h0003});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
